// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nonce_dispatcher: shares one mining job across NUM_ENGINES double-SHA engines.
// Optional DISPATCH_STATS_EN adds hash_count / active_engines.  Rev 1.0
// ----------------------------------------------------------------------------
module nonce_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [511:0]                 job_block0,
  input  logic [511:0]                 job_block1,
  input  logic [255:0]                 job_target,
  input  logic [31:0]                  job_nonce_lo,
  input  logic [31:0]                  job_nonce_hi,
  input  logic                         abort,
  output logic [NUM_ENGINES-1:0]       eng_start,
  output logic [511:0]                 eng_block0,
  output logic [NUM_ENGINES*512-1:0]   eng_block1,
  input  logic [NUM_ENGINES-1:0]       eng_done,
  input  logic [NUM_ENGINES*256-1:0]   eng_hash,
  output logic                         busy,
  output logic                         found,
  output logic [31:0]                  found_nonce,
  output logic [255:0]                 found_hash,
  output logic                         exhausted
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                  hash_count,
  output logic [IDX_W:0]               active_engines
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DISPATCH = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                 state;
  logic [511:0]           blk0_q;
  logic [479:0]           blk1_q;
  logic [255:0]           target_q;
  logic [31:0]            lo_q, hi_q, next_nonce;
  logic                   range_done, aborted;
  logic [NUM_ENGINES-1:0] busy_flag;
  logic [31:0]            eng_nonce [NUM_ENGINES];

  // The low word of block1 is always replaced by the engine's nonce.
  logic unused_block1_low;
  assign unused_block1_low = ^job_block1[31:0];

  assign job_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign eng_block0 = blk0_q;

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_blk1
    assign eng_block1[g*512 +: 512] = {blk1_q, eng_nonce[g]};
  end

  logic [NUM_ENGINES-1:0] done_v, hit_v, busy_next, start_v;
  logic                   hit_any, idle_any, take_hit, start_go;
  logic [IDX_W-1:0]       hit_idx, idle_idx;
  logic [IDX_W:0]         done_cnt, busy_cnt;

  always_comb begin
    done_v    = (state == S_IDLE) ? '0 : (eng_done & busy_flag);
    busy_next = busy_flag & ~done_v;
    hit_v     = '0;
    hit_any   = 1'b0;
    hit_idx   = '0;
    idle_any  = 1'b0;
    idle_idx  = '0;
    done_cnt  = '0;
    busy_cnt  = '0;
    // Descending scan so the lowest index wins both priority searches.
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      hit_v[i] = done_v[i] && (eng_hash[i*256 +: 256] <= target_q);
      if (hit_v[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!busy_flag[i]) begin
        idle_any = 1'b1;
        idle_idx = IDX_W'(i);
      end
      done_cnt = done_cnt + {{IDX_W{1'b0}}, done_v[i]};
      busy_cnt = busy_cnt + {{IDX_W{1'b0}}, busy_flag[i]};
    end
    take_hit = hit_any && !found && !aborted && !(abort && state == S_DISPATCH);
    start_go = (state == S_DISPATCH) && !(lo_q > hi_q) && !abort && !take_hit &&
               !range_done && idle_any;
    start_v  = '0;
    if (start_go) start_v[idle_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      blk0_q      <= '0;
      blk1_q      <= '0;
      target_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      next_nonce  <= '0;
      range_done  <= 1'b0;
      aborted     <= 1'b0;
      busy_flag   <= '0;
      eng_start   <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      exhausted   <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) eng_nonce[i] <= '0;
    end else begin
      eng_start <= start_v;
      busy_flag <= busy_next | start_v;

      if (start_go) begin
        eng_nonce[idle_idx] <= next_nonce;
        // range_done rather than a compare on next_nonce lets hi=FFFFFFFF end cleanly
        if (next_nonce == hi_q) range_done <= 1'b1;
        else                    next_nonce <= next_nonce + 32'd1;
      end

      if (take_hit) begin
        found       <= 1'b1;
        found_nonce <= eng_nonce[hit_idx];
        found_hash  <= eng_hash[hit_idx*256 +: 256];
      end

      case (state)
        S_IDLE: begin
          if (job_valid) begin
            blk0_q      <= job_block0;
            blk1_q      <= job_block1[511:32];
            target_q    <= job_target;
            lo_q        <= job_nonce_lo;
            hi_q        <= job_nonce_hi;
            next_nonce  <= job_nonce_lo;
            range_done  <= 1'b0;
            aborted     <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            state       <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (lo_q > hi_q) begin
            exhausted <= 1'b1;
            state     <= S_IDLE;
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= S_DRAIN;
          end else if (take_hit) begin
            state <= S_DRAIN;
          end else if (range_done && busy_next == '0) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (busy_next == '0) begin
            exhausted <= !found && !aborted && !take_hit;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [32:0] hc_sum;
  assign hc_sum         = {1'b0, hash_count} + 33'(done_cnt);
  assign active_engines = busy_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_count <= '0;
    end else if (state == S_IDLE && job_valid) begin
      hash_count <= '0;
    end else if (done_v != '0) begin
      hash_count <= hc_sum[32] ? 32'hFFFF_FFFF : hc_sum[31:0];
    end
  end
`else
  logic unused_counts;
  assign unused_counts = ^{done_cnt, busy_cnt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
`default_nettype none
// Directed bench for nonce_dispatcher with a behavioural engine array model.
`timescale 1ns/1ps
module tb_nonce_dispatcher;
  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               job_valid = 1'b0;
  logic               job_ready;
  logic [511:0]       job_block0 = {16{32'h1357_9BDF}};
  logic [511:0]       job_block1 = {{15{32'h0BAD_F00D}}, 32'hDEAD_BEEF};
  logic [255:0]       job_target = '0;
  logic [31:0]        job_nonce_lo = '0;
  logic [31:0]        job_nonce_hi = '0;
  logic               abort = 1'b0;
  logic [N-1:0]       eng_start;
  logic [511:0]       eng_block0;
  logic [N*512-1:0]   eng_block1;
  logic [N-1:0]       eng_done = '0;
  logic [N*256-1:0]   eng_hash = '1;
  logic               busy, found, exhausted;
  logic [31:0]        found_nonce;
  logic [255:0]       found_hash;
`ifdef DISPATCH_STATS_EN
  logic [31:0]        hash_count;
  logic [2:0]         active_engines;
`endif

  always #5 clk = ~clk;

  nonce_dispatcher #(.NUM_ENGINES(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_block0(job_block0), .job_block1(job_block1), .job_target(job_target),
    .job_nonce_lo(job_nonce_lo), .job_nonce_hi(job_nonce_hi), .abort(abort),
    .eng_start(eng_start), .eng_block0(eng_block0), .eng_block1(eng_block1),
    .eng_done(eng_done), .eng_hash(eng_hash), .busy(busy), .found(found),
    .found_nonce(found_nonce), .found_hash(found_hash), .exhausted(exhausted)
`ifdef DISPATCH_STATS_EN
    , .hash_count(hash_count), .active_engines(active_engines)
`endif
  );

  // Engine model: done pulses lat[i] negedges after the start is seen.
  int           lat [N];
  logic [N-1:0] hit_eng = '0;
  logic         hit_nonce_en = 1'b0;
  logic [31:0]  hit_nonce = '0;
  int           cnt [N];
  logic [N-1:0] pend = '0;
  logic [31:0]  mnonce [N];
  int           total_starts = 0;
  int           start_eng [256];
  int           start_cyc [256];
  logic [31:0]  start_nonce [256];
  int           cyc = 0;
  int           starts_at_found = -1;
  logic         found_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend     = '0;
      eng_done = '0;
      found_d  = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        eng_done[i] = 1'b0;
        if (eng_start[i]) begin
          pend[i]   = 1'b1;
          cnt[i]    = lat[i];
          mnonce[i] = eng_block1[i*512 +: 32];
          if (total_starts < 256) begin
            start_eng[total_starts]   = i;
            start_cyc[total_starts]   = cyc;
            start_nonce[total_starts] = mnonce[i];
          end
          total_starts++;
        end else if (pend[i]) begin
          cnt[i]--;
          if (cnt[i] <= 0) begin
            pend[i]     = 1'b0;
            eng_done[i] = 1'b1;
            if (hit_eng[i] || (hit_nonce_en && mnonce[i] == hit_nonce))
              eng_hash[i*256 +: 256] = {224'd0, mnonce[i]};
            else
              eng_hash[i*256 +: 256] = '1;
          end
        end
      end
      if (found && !found_d) starts_at_found = total_starts;
      found_d = found;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int base     = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] lo, input logic [31:0] hi, input logic [255:0] tgt);
    step();
    job_nonce_lo = lo;
    job_nonce_hi = hi;
    job_target   = tgt;
    job_valid    = 1'b1;
    base         = total_starts;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k;
    k = 0;
    while (!job_ready && k < maxc) begin
      step();
      k++;
    end
    chk({tag, " idle"}, job_ready, 1'b1);
    chk({tag, " pending"}, pend, '0);
  endtask

  initial begin
    logic [7:0] seen;
    for (int i = 0; i < N; i++) lat[i] = 20;

    // Reset values
    repeat (3) step();
    chk("rst job_ready", job_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst found", found, 1'b0);
    chk("rst exhausted", exhausted, 1'b0);
    chk("rst eng_start", eng_start, '0);
    chk("rst found_nonce", found_nonce, '0);
    chk("rst found_hash", found_hash, '0);
    chk("rst eng_block0", eng_block0, '0);
    rst = 1'b0;

    // 1: full range 0..7, no hit
    start_job(32'd0, 32'd7, 256'd0);
    wait_idle(400, "t1");
    chk("t1 starts", total_starts - base, 8);
    for (int k = 0; k < 4; k++) begin
      chk("t1 start engine", start_eng[base+k], k);
      chk("t1 start cycle", start_cyc[base+k], start_cyc[base] + k);
    end
    seen = '0;
    for (int k = 0; k < 8; k++)
      if (start_nonce[base+k] < 8) seen[start_nonce[base+k][2:0]] = 1'b1;
    chk("t1 nonce cover", seen, 8'hFF);
    chk("t1 exhausted", exhausted, 1'b1);
    chk("t1 found", found, 1'b0);
    chk("t1 busy", busy, 1'b0);
    chk("t1 block0", eng_block0, job_block0);
    chk("t1 block1 e2", eng_block1[2*512 +: 512], {job_block1[511:32], 32'd6});

    // 2: single hit on nonce 105
    hit_nonce_en = 1'b1;
    hit_nonce    = 32'd105;
    start_job(32'd100, 32'd1000, 256'hFFFF_FFFF);
    wait_idle(600, "t2");
    chk("t2 found", found, 1'b1);
    chk("t2 found_nonce", found_nonce, 32'd105);
    chk("t2 found_hash", found_hash, {224'd0, 32'd105});
    chk("t2 exhausted", exhausted, 1'b0);
    chk("t2 no start after hit", starts_at_found, total_starts);
    hit_nonce_en = 1'b0;

    // 3: engines 1 and 3 hit in the same cycle
    lat[0] = 30; lat[1] = 12; lat[2] = 30; lat[3] = 10;
    hit_eng = 4'b1010;
    start_job(32'd50, 32'd60, 256'hFFFF_FFFF);
    wait_idle(300, "t3");
    chk("t3 found", found, 1'b1);
    chk("t3 found_nonce", found_nonce, 32'd51);
    chk("t3 found_hash", found_hash, {224'd0, 32'd51});
    hit_eng = '0;
    for (int i = 0; i < N; i++) lat[i] = 20;

    // 4: top of the nonce space
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'd0);
    wait_idle(300, "t4");
    chk("t4 starts", total_starts - base, 2);
    chk("t4 nonce a", start_nonce[base], 32'hFFFF_FFFE);
    chk("t4 nonce b", start_nonce[base+1], 32'hFFFF_FFFF);
    chk("t4 exhausted", exhausted, 1'b1);

    // 5: abort with three engines in flight; the hit on 201 is ignored
    hit_nonce_en = 1'b1;
    hit_nonce    = 32'd201;
    start_job(32'd200, 32'd300, 256'hFFFF_FFFF);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 starts at abort", total_starts - base, 3);
    chk("t5 busy", busy, 1'b1);
    wait_idle(300, "t5");
    chk("t5 starts final", total_starts - base, 3);
    chk("t5 found", found, 1'b0);
    chk("t5 exhausted", exhausted, 1'b0);
    chk("t5 found_nonce", found_nonce, 32'd0);
    hit_nonce_en = 1'b0;

    // 6: empty range
    start_job(32'd10, 32'd5, 256'd0);
    chk("t6 busy", busy, 1'b1);
    step();
    chk("t6 exhausted", exhausted, 1'b1);
    chk("t6 job_ready", job_ready, 1'b1);
    chk("t6 starts", total_starts - base, 0);

    // 7: reset mid-dispatch, then a short job afterwards
    start_job(32'd0, 32'd1000, 256'd0);
    repeat (3) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t7 job_ready", job_ready, 1'b1);
    chk("t7 busy", busy, 1'b0);
    chk("t7 eng_start", eng_start, '0);
    chk("t7 exhausted", exhausted, 1'b0);
    chk("t7 eng_block0", eng_block0, '0);
    step();
    rst = 1'b0;
    step();
    start_job(32'd3, 32'd4, 256'd0);
    wait_idle(300, "t7b");
    chk("t7b starts", total_starts - base, 2);
    chk("t7b exhausted", exhausted, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Job-level controller that shares one mining job across NUM_ENGINES double-SHA-256 engines. Each engine has a start/done handshake and a 256-bit hash result.
- Splits an inclusive nonce range [nonce_lo, nonce_hi] by handing nonces to idle engines one at a time.
- Compares every returned hash against the job target and reports the first hit, or reports exhaustion.
- Sits between the host/job interface and the engine array. Supersedes the single-engine sequential nonce loop.

Parameters:
NUM_ENGINES, 4, number of attached double-SHA engines (1..16)
IDX_W, 2, width of the engine index; must equal ceil(log2(NUM_ENGINES)), minimum 1

Ports:
clk  input  1  clock
rst  input  1  reset
job_valid  input  1  job offer
job_ready  output  1  high only in S_IDLE
job_block0  input  512  first SHA block (fixed)
job_block1  input  512  second block template; bits [31:0] ignored (replaced by nonce)
job_target  input  256  difficulty target
job_nonce_lo  input  32  first nonce (inclusive)
job_nonce_hi  input  32  last nonce (inclusive)
abort  input  1  cancel current job
eng_start  output  NUM_ENGINES  one-cycle start pulse per engine
eng_block0  output  512  latched job_block0, shared by all engines
eng_block1  output  NUM_ENGINES*512  per engine: {latched block1[511:32], eng_nonce[i]}, slice i at [i*512 +: 512]
eng_done  input  NUM_ENGINES  one-cycle completion pulse per engine
eng_hash  input  NUM_ENGINES*256  result of engine i at [i*256 +: 256], valid while eng_done[i]=1
busy  output  1  job in progress (S_DISPATCH or S_DRAIN)
found  output  1  hit reported for last job
found_nonce  output  32  winning nonce
found_hash  output  256  winning hash
exhausted  output  1  range finished without a hit

Behaviour:
Reset and clocking:
- rst: asynchronous, active-high. clk: rising edge.
- On reset: state=S_IDLE; all engine-busy flags 0; eng_start=0; busy=0; found=0; exhausted=0; found_nonce=0; found_hash=0; latched job registers=0.
- Reset mid-job drops all state. Engines are assumed to be reset by the same rst.

Job acceptance:
- Job is accepted on a cycle where job_valid && job_ready.
- On accept: latch block0, block1, target, lo, hi; next_nonce<=lo; range_done<=0; found<=0; exhausted<=0; found_nonce<=0; found_hash<=0; state<=S_DISPATCH.
- If lo>hi, the job is accepted, then exhausted=1 is set and the block returns to S_IDLE on the next cycle with no engine started.

S_DISPATCH:
- Each cycle, if !range_done and at least one engine is idle, pick the lowest-index idle engine i.
- Pulse eng_start[i] for exactly 1 cycle; eng_nonce[i]<=next_nonce; busy_flag[i]<=1.
- If next_nonce==hi, set range_done<=1; otherwise next_nonce<=next_nonce+1.
- The range_done flag makes hi=32'hFFFFFFFF terminate correctly with no wrap.
- At most one start per cycle. eng_nonce[i] stays stable until that engine's done.

Completion handling (any state except S_IDLE):
- Any eng_done[i] clears busy_flag[i] in the same cycle.
- A flag cleared this cycle cannot be re-dispatched in the same cycle; it becomes eligible next cycle.
- Hit test: unsigned eng_hash[i] <= target.
- Only if found==0 and not aborted: among simultaneous hits, the lowest index wins. Capture found_nonce=eng_nonce[i] and found_hash, set found<=1, state<=S_DRAIN.
- Hits arriving after the first, or during an abort drain, are ignored.

Exit conditions:
- S_DISPATCH -> S_DRAIN when range_done and all busy_flags are 0 after this cycle's completions.
- abort in S_DISPATCH -> S_DRAIN immediately, with the aborted flag set.
- S_DRAIN: no new starts. Wait until all busy_flags are 0, then return to S_IDLE.
- On return to S_IDLE, if !found && !aborted, set exhausted<=1.
- abort is ignored in S_IDLE. The aborted flag is cleared on the next accept.

Output holding:
- found, found_nonce, found_hash and exhausted hold until the next job is accepted.
- eng_done for an engine whose busy_flag is already 0 is ignored.

Optional Feature:
Macro DISPATCH_STATS_EN.
- Defined: adds output hash_count[31:0], which counts engine completions since the last job accept (cleared on accept, saturating at 32'hFFFFFFFF). Also adds output active_engines[IDX_W:0], the population count of busy_flags.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- NUM_ENGINES=4, lo=0, hi=7, target=0 (no hit), engines return done 20 cycles after start -> starts on engines 0,1,2,3 in consecutive cycles, 8 starts total, nonces 0..7 each issued once, then exhausted=1, found=0, job_ready=1.
- lo=100, hi=1000; bench returns hash <= target only for nonce 105 -> found=1, found_nonce=105, found_hash matches, no starts after the hit, busy drops only after all outstanding dones.
- Engines 1 and 3 both return hitting hashes in the same cycle -> found_nonce equals engine 1's nonce.
- lo=32'hFFFFFFFE, hi=32'hFFFFFFFF, no hit -> exactly 2 starts, no nonce 0 issued, exhausted=1.
- abort asserted 3 cycles after accept with 3 engines in flight -> no further starts, busy stays 1 until 3 dones, then found=0, exhausted=0. A hit in the drained results is ignored.
- lo=10, hi=5 -> no eng_start, exhausted=1 one cycle after accept. Separately: assert rst mid-dispatch -> all outputs at reset values on the following edge.
